// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants, digit codes and frame helpers for seg_scan_decoder.
// Segment patterns are active-low g..a; digit codes are 4-bit.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;
    localparam logic [3:0] DIG_INV   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_CONVERT,
        ST_DONE
    } state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        logic [3:0] d;
        unique case (s)
            SEG_0:     d = 4'd0;
            SEG_1:     d = 4'd1;
            SEG_2:     d = 4'd2;
            SEG_3:     d = 4'd3;
            SEG_4:     d = 4'd4;
            SEG_5:     d = 4'd5;
            SEG_6:     d = 4'd6;
            SEG_7:     d = 4'd7;
            SEG_8:     d = 4'd8;
            SEG_9:     d = 4'd9;
            SEG_MINUS: d = DIG_MINUS;
            SEG_BLANK: d = DIG_BLANK;
            default:   d = DIG_INV;
        endcase
        return d;
    endfunction

    // Scan from the MS digit: blanks, at most one minus,
    // then numerals only; the units digit must be a numeral.
    function automatic logic frame_ok(input logic [23:0] f);
        logic       ok;
        logic       seen;
        logic [3:0] d;
        ok   = 1'b1;
        seen = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            d = f[i*4 +: 4];
            if (d <= 4'd9)
                seen = 1'b1;
            else if (!seen && (d == DIG_BLANK || d == DIG_MINUS))
                seen = (d == DIG_MINUS);
            else
                ok = 1'b0;
        end
        if (f[3:0] > 4'd9)
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic frame_neg(input logic [23:0] f);
        logic n;
        n = 1'b0;
        for (int i = 0; i < 6; i++)
            if (f[i*4 +: 4] == DIG_MINUS)
                n = 1'b1;
        return n;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_bcd_to_bin.sv
// Iterative 6-digit BCD to binary, MS digit first, acc = acc*10 + d.
// Ports: start pulse, bcd_in[23:0], bin_out[19:0], done pulse.
module seg_scan_decoder_bcd_to_bin (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [23:0] bcd_in,
    output logic [19:0] bin_out,
    output logic        done
);

    logic [23:0] sh;
    logic [19:0] acc;
    logic [2:0]  cnt;
    logic        busy;
    logic [3:0]  d;
    logic [19:0] acc_nx;

    // Blank and minus codes contribute zero.
    assign d      = (sh[23:20] > 4'd9) ? 4'd0 : sh[23:20];
    assign acc_nx = (acc << 3) + (acc << 1) + {16'd0, d};
    assign bin_out = acc;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh   <= bcd_in;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_nx;
                sh  <= sh << 4;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd5) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 6-digit 7-seg bus and rebuilds the frame.
// In: sys_clk, sys_rst_n, sel_in, seg_in. Out: data/point/sign, pulses, scan_lost.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter logic [15:0] STABLE_CYC  = 16'd1000,
    parameter logic [19:0] TIMEOUT_CYC = 20'd500_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [5:0]  sel_in,
    input  logic [7:0]  seg_in,
    output logic [19:0] data_out,
    output logic [5:0]  point_out,
    output logic        sign_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        scan_lost
);

    logic [5:0]  sel_m, sel_s, sel_p;
    logic [7:0]  seg_m, seg_s, seg_p;
    logic [15:0] stab_cnt;
    logic        sampled;
    logic        same;
    logic        onehot;
    logic        samp;
    logic [2:0]  idx;
    logic [3:0]  dig;
    logic        dot;
    logic [19:0] to_cnt;
    logic        timeout;

    state_t      state;
    logic [23:0] digits;
    logic [5:0]  dots;
    logic [2:0]  exp_idx;
    logic        check_ok;
    logic        bcd_start;
    logic [19:0] bcd_bin;
    logic        bcd_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_m <= '0;
            sel_s <= '0;
            sel_p <= '0;
            seg_m <= 8'hFF;
            seg_s <= 8'hFF;
            seg_p <= 8'hFF;
        end else begin
            sel_m <= sel_in;
            sel_s <= sel_m;
            sel_p <= sel_s;
            seg_m <= seg_in;
            seg_s <= seg_m;
            seg_p <= seg_s;
        end
    end

    assign same   = ({sel_s, seg_s} == {sel_p, seg_p});
    assign onehot = (sel_s != 6'd0) &&
                    ((sel_s & (sel_s - 6'd1)) == 6'd0);
    assign samp   = same && !sampled && onehot &&
                    (stab_cnt >= STABLE_CYC - 16'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stab_cnt <= '0;
            sampled  <= 1'b0;
        end else if (!same) begin
            stab_cnt <= '0;
            sampled  <= 1'b0;
        end else begin
            if (stab_cnt != 16'hFFFF)
                stab_cnt <= stab_cnt + 16'd1;
            if (samp)
                sampled <= 1'b1;
        end
    end

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 6; i++)
            if (sel_s[i])
                idx = 3'(i);
    end

    assign dig = seg_decode(seg_s[6:0]);
    assign dot = ~seg_s[7];

    // A sample in the same cycle always wins over the timeout.
    assign timeout = !samp && (to_cnt == TIMEOUT_CYC - 20'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt    <= '0;
            scan_lost <= 1'b0;
        end else if (samp) begin
            to_cnt    <= '0;
            scan_lost <= 1'b0;
        end else begin
            if (to_cnt != TIMEOUT_CYC)
                to_cnt <= to_cnt + 20'd1;
            if (timeout)
                scan_lost <= 1'b1;
        end
    end

    assign check_ok  = frame_ok(digits);
    assign bcd_start = (state == ST_CHECK) && check_ok && !timeout;

    seg_scan_decoder_bcd_to_bin u_bcd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (bcd_start),
        .bcd_in    (digits),
        .bin_out   (bcd_bin),
        .done      (bcd_done)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            digits      <= '0;
            dots        <= '0;
            exp_idx     <= '0;
            data_out    <= '0;
            point_out   <= '0;
            sign_out    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (timeout) begin
                // Partial frame dropped without an error pulse.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (samp && idx == 3'd0) begin
                            digits[3:0] <= dig;
                            dots[0]     <= dot;
                            exp_idx     <= 3'd1;
                            state       <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (samp && idx == exp_idx) begin
                            digits[{idx, 2'b00} +: 4] <= dig;
                            dots[idx] <= dot;
                            if (exp_idx == 3'd5)
                                state <= ST_CHECK;
                            else
                                exp_idx <= exp_idx + 3'd1;
                        end else if (samp) begin
                            frame_err <= 1'b1;
                            if (idx == 3'd0) begin
                                digits[3:0] <= dig;
                                dots[0]     <= dot;
                                exp_idx     <= 3'd1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (check_ok) begin
                            state <= ST_CONVERT;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_CONVERT: begin
                        if (bcd_done) begin
                            data_out    <= bcd_bin;
                            point_out   <= dots;
                            sign_out    <= frame_neg(digits);
                            frame_valid <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 6-digit seven-segment bus: samples sel_in/seg_in and reconstructs the displayed frame as binary value, sign and decimal points.
- Used as an on-chip self-check monitor and bench scoreboard for the display path of the temperature design.
- Expected scan: one-hot sel walking 000001 to 100000; active-low segments, seg[7] = dot.

Parameters:
- STABLE_CYC, 16'd1000: cycles {sel,seg} must hold unchanged before one digit is sampled.
- TIMEOUT_CYC, 20'd500_000: cycles without a sample before scan_lost asserts (10 ms at 50 MHz).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- sel_in  in  6  digit select from the display driver; one-hot, bit0 = units.
- seg_in  in  8  segment lines, active low; [7] = dot, [6:0] = g..a.
- data_out  out  20  magnitude of the last good frame; reset 0.
- point_out  out  6  dot per digit, 1 = lit; reset 0.
- sign_out  out  1  1 = minus shown in the last good frame; reset 0.
- frame_valid  out  1  one-cycle pulse when the outputs above update; reset 0.
- frame_err  out  1  one-cycle pulse when a frame is rejected; reset 0.
- scan_lost  out  1  level; no sample for TIMEOUT_CYC cycles; reset 0.

Behaviour:
- Input sync: 2-flop synchronizers on sel_in and seg_in. Reset values: sel 0, seg 8'hFF.
- Stability counter:
  - Cleared whenever synced {sel,seg} differs from the previous cycle; otherwise increments, saturating.
  - A sample fires once when the count reaches STABLE_CYC-1 and sel is one-hot.
  - A sampled flag blocks re-sampling until {sel,seg} changes.
  - sel = 0 or multi-hot is ignored and is not an error.
- Digit decode on seg[6:0]:
  - 40,79,24,30,19,12,02,78,00,10 (hex) decode to 0..9.
  - 3F decodes to code 10 (minus); 7F to code 11 (blank); anything else to 15 (invalid).
  - dot = ~seg[7].
- Frame FSM states: IDLE, COLLECT, CHECK, CONVERT, DONE.
  - IDLE: a sample with sel=000001 stores digit0 and moves to COLLECT, expecting index 1. Other samples are ignored.
  - COLLECT: a sample at the expected index is stored and the index increments. A sample at any other index pulses frame_err and discards the frame.
    - If that unexpected sample is digit0, it is stored as the start of a new frame (expect index 1).
    - Otherwise the FSM returns to IDLE.
  - COLLECT: after digit5 is stored, go to CHECK.
  - CHECK (1 cycle): reading from digit5 down, the frame must be leading blanks, then at most one minus, then numerals only. digit0 must be a numeral; no code 15 anywhere.
    - Pass: go to CONVERT.
    - Fail: pulse frame_err, go to IDLE.
  - CONVERT: bcd_to_bin runs 6 cycles, MS digit first, acc = acc*10 + d; blank and minus count as 0. Maximum 999999 fits 20 bits.
  - DONE (1 cycle): register data_out, point_out, sign_out; pulse frame_valid; go to IDLE.
  - frame_valid rises 9 cycles after the digit5 sample strobe.
- Outputs hold their last good frame across errors and scan loss.
- Timeout: a counter clears on every sample.
  - At TIMEOUT_CYC it sets scan_lost, forces the FSM to IDLE, and silently drops any partial frame (no frame_err).
  - The next sample clears scan_lost.
- Simultaneous events: a timeout and a sample in the same cycle resolve to the sample.
- Reset asserted mid-frame returns all registers and outputs to their reset values immediately.

Decomposition:
- Shared package:
  - Seven-segment code constants: SEG_0..SEG_9, SEG_MINUS=7'h3F, SEG_BLANK=7'h7F.
  - Digit codes: DIG_MINUS=4'd10, DIG_BLANK=4'd11, DIG_INV=4'd15.
  - FSM state encoding.
- Sub-module bcd_to_bin: start pulse, 24-bit BCD in, 20-bit out, done pulse; iterative x10 implemented as shift-add.

Test Plan (bench parameters STABLE_CYC=4, TIMEOUT_CYC=200; each digit held 20 cycles):
- Scan blank,1,2,3,4,5 (digit5..0) -> data_out=12345, sign_out=0, point_out=0; exactly one frame_valid pulse per frame.
- Scan blank,blank,blank,minus,2,5 with dot on digit1 -> data_out=25, sign_out=1, point_out=6'b000010.
- sel sequence 000001, 000010, 001000 -> frame_err pulses once at the 001000 sample; outputs keep their previous frame.
- Digit2 pattern 7'h55, or minus placed at digit0 -> frame_err after digit5 and no frame_valid; a 2-cycle glitch on seg produces no extra sample.
- Stop the scan (sel=0) for 200 cycles -> scan_lost=1 and the partial frame is dropped; resume -> scan_lost=0 at the first sample; the next full frame (e.g. 999999) gives data_out=999999.
- Assert sys_rst_n low in mid-COLLECT -> all outputs 0 at once; after release, the first complete frame is decoded correctly.
